hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_load_use_detect.sv | 35 +++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// These definitions are shared by the hazard controller and its load-use
// detector:
//   state_t    : controller FSM states (RUN, MEM_WAIT)
//   WAIT_LIMIT : memory-wait count at which the timeout flag is raised
//   REG_ZERO   : architectural zero register ($zero). Its value is never
//                forwarded, so a load into it creates no hazard.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'd15;
    localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// This block is purely combinational. It flags a load-use hazard when the load
// now in EX writes a register that the instruction in ID reads.
// Ports:
//   ex_mem_to_reg : EX instruction is a load
//   ex_wr_addr    : EX destination register
//   id_rs_addr    : ID rs field
//   id_rt_addr    : ID rt field
//   id_uses_rt    : ID instruction actually reads rt
//   hazard        : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       ex_mem_to_reg,
    input  logic [4:0] ex_wr_addr,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_wr_addr == id_rs_addr);
        // rt counts only for instructions that read it. For an I-type ALU op
        // the rt field is a destination, so a match there is not a hazard.
        rt_match = id_uses_rt && (ex_wr_addr == id_rt_addr);
        hazard   = ex_mem_to_reg && (ex_wr_addr != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller. It handles load-use stalls, branch flushes
// resolved in ID, and freezes for multi-cycle data-memory accesses. It also
// provides a memory timeout flag and a stall-cycle counter.
// Ports:
//   clk, rst           : clock; asynchronous active-high reset
//   ID_rsAddr/rtAddr   : source fields of the ID instruction
//   ID_UsesRt          : ID instruction reads rt
//   ID_PCSrc           : branch/jump taken in ID
//   EX_MemtoReg        : EX instruction is a load
//   EX_wrAddr          : EX destination register
//   MEM_MemReq         : MEM instruction accesses data memory
//   MEM_Ready          : data memory completes this cycle
//   PC_En, IF_ID_En    : front-end enables (combinational)
//   IF_ID_Clr          : flush of IF/ID (combinational)
//   ID_EX_Clr          : bubble into ID/EX (combinational)
//   Pipe_Freeze        : hold ID/EX, EX/MEM, MEM/WB (combinational)
//   MEM_WB_Clr         : bubble into MEM/WB (combinational)
//   MemTimeout         : sticky memory-wait timeout (registered)
//   StallCycles        : saturating count of PC_En=0 cycles (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rsAddr,
    input  logic [4:0]  ID_rtAddr,
    input  logic        ID_UsesRt,
    input  logic        ID_PCSrc,
    input  logic        EX_MemtoReg,
    input  logic [4:0]  EX_wrAddr,
    input  logic        MEM_MemReq,
    input  logic        MEM_Ready,
    output logic        PC_En,
    output logic        IF_ID_En,
    output logic        IF_ID_Clr,
    output logic        ID_EX_Clr,
    output logic        Pipe_Freeze,
    output logic        MEM_WB_Clr,
    output logic        MemTimeout,
    output logic [15:0] StallCycles
);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        mem_timeout_reg;
    logic [15:0] stall_cnt_reg;

    logic        load_use;
    logic        mem_stall;

    load_use_detect u_load_use_detect (
        .ex_mem_to_reg (EX_MemtoReg),
        .ex_wr_addr    (EX_wrAddr),
        .id_rs_addr    (ID_rsAddr),
        .id_rt_addr    (ID_rtAddr),
        .id_uses_rt    (ID_UsesRt),
        .hazard        (load_use)
    );

    // In MEM_WAIT only MEM_Ready matters. The access being waited on is
    // frozen in MEM, so MEM_MemReq is known to be set. The cycle in which
    // Ready arrives uses the normal RUN rules.
    always_comb begin
        if (state_reg == MEM_WAIT) begin
            mem_stall = !MEM_Ready;
        end else begin
            mem_stall = MEM_MemReq && !MEM_Ready;
        end
    end

    // Priority order: reset, then memory wait, then load-use, then branch
    // flush. When load-use and a taken branch occur together, the stall
    // suppresses the flush. The branch stays in ID and resolves again on the
    // next cycle.
    always_comb begin
        PC_En       = 1'b1;
        IF_ID_En    = 1'b1;
        IF_ID_Clr   = 1'b0;
        ID_EX_Clr   = 1'b0;
        Pipe_Freeze = 1'b0;
        MEM_WB_Clr  = 1'b0;
        if (rst) begin
            PC_En    = 1'b0;
            IF_ID_En = 1'b0;
        end else if (mem_stall) begin
            PC_En       = 1'b0;
            IF_ID_En    = 1'b0;
            Pipe_Freeze = 1'b1;
            MEM_WB_Clr  = 1'b1;
        end else if (load_use) begin
            PC_En     = 1'b0;
            IF_ID_En  = 1'b0;
            ID_EX_Clr = 1'b1;
        end else if (ID_PCSrc) begin
            IF_ID_Clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 4'd0;
            mem_timeout_reg <= 1'b0;
            stall_cnt_reg   <= 16'd0;
        end else begin
            if (!PC_En && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            case (state_reg)
                RUN: begin
                    if (MEM_MemReq && !MEM_Ready) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= 4'd0;
                    end
                end
                MEM_WAIT: begin
                    if (MEM_Ready) begin
                        state_reg <= RUN;
                    end else begin
                        if (wait_cnt_reg != WAIT_LIMIT) begin
                            wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        end
                        // The flag is raised on the same edge at which the
                        // counter reaches the limit.
                        if (wait_cnt_reg == (WAIT_LIMIT - 4'd1)) begin
                            mem_timeout_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign MemTimeout  = mem_timeout_reg;
    assign StallCycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A behavioural reference model tracks
// whether a memory access is pending, how long it has waited, the timeout
// flag, and the number of stalled cycles. Expected outputs are derived from
// the hazard priority rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rsAddr;
    logic [4:0]  ID_rtAddr;
    logic        ID_UsesRt;
    logic        ID_PCSrc;
    logic        EX_MemtoReg;
    logic [4:0]  EX_wrAddr;
    logic        MEM_MemReq;
    logic        MEM_Ready;
    logic        PC_En;
    logic        IF_ID_En;
    logic        IF_ID_Clr;
    logic        ID_EX_Clr;
    logic        Pipe_Freeze;
    logic        MEM_WB_Clr;
    logic        MemTimeout;
    logic [15:0] StallCycles;

    int vectors    = 0;
    int miscompares = 0;

    // reference model
    bit m_waiting;
    int m_wait_count;
    bit m_timeout;
    int m_stalls;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ID_rsAddr   (ID_rsAddr),
        .ID_rtAddr   (ID_rtAddr),
        .ID_UsesRt   (ID_UsesRt),
        .ID_PCSrc    (ID_PCSrc),
        .EX_MemtoReg (EX_MemtoReg),
        .EX_wrAddr   (EX_wrAddr),
        .MEM_MemReq  (MEM_MemReq),
        .MEM_Ready   (MEM_Ready),
        .PC_En       (PC_En),
        .IF_ID_En    (IF_ID_En),
        .IF_ID_Clr   (IF_ID_Clr),
        .ID_EX_Clr   (ID_EX_Clr),
        .Pipe_Freeze (Pipe_Freeze),
        .MEM_WB_Clr  (MEM_WB_Clr),
        .MemTimeout  (MemTimeout),
        .StallCycles (StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic pcsrc, input logic ld, input logic [4:0] wr,
                         input logic req, input logic rdy);
        ID_rsAddr   = rs;
        ID_rtAddr   = rt;
        ID_UsesRt   = uses_rt;
        ID_PCSrc    = pcsrc;
        EX_MemtoReg = ld;
        EX_wrAddr   = wr;
        MEM_MemReq  = req;
        MEM_Ready   = rdy;
    endtask

    // One pipeline cycle. The combinational outputs are checked at the falling
    // edge. The model then advances at the rising edge, and the registered
    // outputs are checked just after it.
    task automatic step(input string tag);
        bit lu, mw;
        bit e_pc, e_ifid, e_ifclr, e_idclr, e_frz, e_wbclr;
        @(negedge clk);
        lu = EX_MemtoReg && (EX_wrAddr != 0) &&
             ((EX_wrAddr == ID_rsAddr) || (ID_UsesRt && (EX_wrAddr == ID_rtAddr)));
        mw = !MEM_Ready && (m_waiting || MEM_MemReq);
        e_pc = 1; e_ifid = 1; e_ifclr = 0; e_idclr = 0; e_frz = 0; e_wbclr = 0;
        if (mw) begin
            e_pc = 0; e_ifid = 0; e_frz = 1; e_wbclr = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_idclr = 1;
        end else if (ID_PCSrc) begin
            e_ifclr = 1;
        end
        chk({tag, ".PC_En"},       16'(PC_En),       16'(e_pc));
        chk({tag, ".IF_ID_En"},    16'(IF_ID_En),    16'(e_ifid));
        chk({tag, ".IF_ID_Clr"},   16'(IF_ID_Clr),   16'(e_ifclr));
        chk({tag, ".ID_EX_Clr"},   16'(ID_EX_Clr),   16'(e_idclr));
        chk({tag, ".Pipe_Freeze"}, 16'(Pipe_Freeze), 16'(e_frz));
        chk({tag, ".MEM_WB_Clr"},  16'(MEM_WB_Clr),  16'(e_wbclr));
        @(posedge clk);
        if (!e_pc && m_stalls < 65535) m_stalls++;
        if (!m_waiting) begin
            if (MEM_MemReq && !MEM_Ready) begin
                m_waiting    = 1;
                m_wait_count = 0;
            end
        end else if (MEM_Ready) begin
            m_waiting = 0;
        end else begin
            if (m_wait_count < 15) m_wait_count++;
            if (m_wait_count == 15) m_timeout = 1;
        end
        #1;
        chk({tag, ".MemTimeout"},  16'(MemTimeout), 16'(m_timeout));
        chk({tag, ".StallCycles"}, StallCycles,     16'(m_stalls));
        $display("step %-10s pc=%b ifid=%b ifclr=%b idclr=%b frz=%b wbclr=%b to=%b stalls=%0d",
                 tag, e_pc, e_ifid, e_ifclr, e_idclr, e_frz, e_wbclr, MemTimeout, StallCycles);
    endtask

    // Asserts reset away from a clock edge and checks the immediate effect.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, ".rst.PC_En"},       16'(PC_En),       16'd0);
        chk({tag, ".rst.IF_ID_En"},    16'(IF_ID_En),    16'd0);
        chk({tag, ".rst.IF_ID_Clr"},   16'(IF_ID_Clr),   16'd0);
        chk({tag, ".rst.ID_EX_Clr"},   16'(ID_EX_Clr),   16'd0);
        chk({tag, ".rst.Pipe_Freeze"}, 16'(Pipe_Freeze), 16'd0);
        chk({tag, ".rst.MEM_WB_Clr"},  16'(MEM_WB_Clr),  16'd0);
        chk({tag, ".rst.MemTimeout"},  16'(MemTimeout),  16'd0);
        chk({tag, ".rst.StallCycles"}, StallCycles,      16'd0);
        m_waiting = 0; m_wait_count = 0; m_timeout = 0; m_stalls = 0;
        $display("reset %s", tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        do_reset("init");

        // load into $t0 followed by a use of $t0: a one-cycle stall
        drive(8, 9, 1, 0, 1, 8, 0, 1); step("lu_rs");
        drive(8, 9, 1, 0, 0, 8, 0, 1); step("lu_after");
        chk("lu.stall_count", StallCycles, 16'd1);

        // a load into $zero never stalls
        drive(0, 0, 1, 0, 1, 0, 0, 1); step("lu_zero");
        // an rt match counts only when rt is read
        drive(3, 8, 1, 0, 1, 8, 0, 1); step("lu_rt");
        drive(3, 8, 0, 0, 1, 8, 0, 1); step("lu_rt_unused");

        // taken branch without a hazard flushes for exactly one cycle
        drive(1, 2, 1, 1, 0, 0, 0, 1); step("br");
        drive(1, 2, 1, 0, 0, 0, 0, 1); step("br_after");

        // stall beats flush; the branch flushes on the next cycle
        drive(5, 6, 1, 1, 1, 5, 0, 1); step("lu_br");
        drive(5, 6, 1, 1, 0, 0, 0, 1); step("lu_br_next");

        // memory wait: one entry cycle plus three waiting cycles, then Ready
        drive(5, 6, 1, 1, 1, 5, 1, 0); step("mw_enter");
        drive(5, 6, 1, 0, 1, 5, 1, 0); step("mw_1");
        drive(5, 6, 1, 0, 1, 5, 1, 0); step("mw_2");
        drive(5, 6, 1, 0, 1, 5, 1, 0); step("mw_3");
        drive(5, 6, 1, 0, 1, 5, 1, 1); step("mw_ready");
        drive(5, 6, 1, 0, 0, 5, 0, 1); step("mw_run");
        chk("mw.MemTimeout", 16'(MemTimeout), 16'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
            step("rand");
        end

        // a long memory wait reaches the timeout; reset in the middle of the
        // wait aborts it
        do_reset("pre_to");
        for (int i = 0; i < 21; i++) begin
            drive(1, 2, 1, 0, 0, 0, 1, 0);
            step("to_wait");
        end
        chk("to.MemTimeout", 16'(MemTimeout), 16'd1);
        do_reset("mid_wait");
        drive(1, 2, 1, 0, 0, 0, 0, 1); step("after_rst");
        chk("after_rst.PC_En", 16'(PC_En), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
